// File: rtl/decode_stage.sv
// Instruction decode stage: registers decoded fields/controls behind a
// valid/ready handshake and discards a fixed number of slots after a taken branch.
module decode_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int FLUSH_SLOTS = 1,
    localparam int IW = 7 + 2*REG_ADDR_W + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IW-1:0]         instruction,
    input  logic                  Z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            opcode,
    output logic [REG_ADDR_W-1:0] a_sel,
    output logic [REG_ADDR_W-1:0] dst,
    output logic [DATA_WIDTH-1:0] b_sel,
    output logic                  mux_b_addr,
    output logic                  ram_read_mux,
    output logic                  store_decoder,
    output logic                  ram_ena,
    output logic                  ram_wena,
    output logic                  register_load,
    output logic                  branch,
    output logic                  illegal,
    output logic                  flush_active
);

    localparam logic [4:0] OP_LD  = 5'h01;
    localparam logic [4:0] OP_ST  = 5'h02;
    localparam logic [4:0] OP_BZ  = 5'h10;
    localparam logic [4:0] OP_BNZ = 5'h11;
    localparam logic [4:0] OP_BRA = 5'h12;
    localparam logic [2:0] SLOTS  = 3'(FLUSH_SLOTS);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                  state, state_nx;
    logic [2:0]              cnt, cnt_nx;
    logic [4:0]              f_op;
    logic [1:0]              f_mode;
    logic [REG_ADDR_W-1:0]   f_a, f_dst;
    logic [DATA_WIDTH-1:0]   f_b;
    logic                    accept, load, is_alu, legal;
    logic d_mux, d_rmux, d_st, d_ena, d_wena, d_rl, d_br, d_ill;

    assign f_op   = instruction[IW-1 -: 5];
    assign f_mode = instruction[IW-6 -: 2];
    assign f_a    = instruction[IW-8 -: REG_ADDR_W];
    assign f_dst  = instruction[IW-8-REG_ADDR_W -: REG_ADDR_W];
    assign f_b    = instruction[DATA_WIDTH-1:0];

    assign in_ready     = reset && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign load         = accept && (state == RUN);
    assign flush_active = (state == FLUSH);

    assign is_alu = (f_op >= 5'h03) && (f_op <= 5'h0A);
    assign legal  = (f_mode != 2'b11) &&
                    (is_alu || f_op == OP_LD || f_op == OP_ST ||
                     f_op == OP_BZ || f_op == OP_BNZ || f_op == OP_BRA);

    always_comb begin
        d_mux  = 1'b0;
        d_rmux = 1'b0;
        d_st   = 1'b0;
        d_ena  = 1'b0;
        d_wena = 1'b0;
        d_rl   = 1'b0;
        d_br   = 1'b0;
        d_ill  = 1'b0;
        if (!legal) begin
            d_ill = 1'b1;
        end else begin
            unique case (1'b1)
                (f_op == OP_LD): begin
                    d_rl   = 1'b1;
                    d_ena  = (f_mode == 2'b01);
                    d_rmux = (f_mode == 2'b01);
                end
                (f_op == OP_ST): begin
                    d_ena  = 1'b1;
                    d_wena = 1'b1;
                    d_st   = 1'b1;
                end
                is_alu:           d_rl = 1'b1;
                (f_op == OP_BZ):  d_br = Z;
                (f_op == OP_BNZ): d_br = !Z;
                (f_op == OP_BRA): d_br = 1'b1;
                default: ;
            endcase
        end
        // illegal words become a NOP, so the B-mux select is suppressed too
        d_mux = (f_mode == 2'b10) && !d_ill;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            opcode        <= '0;
            a_sel         <= '0;
            dst           <= '0;
            b_sel         <= '0;
            mux_b_addr    <= 1'b0;
            ram_read_mux  <= 1'b0;
            store_decoder <= 1'b0;
            ram_ena       <= 1'b0;
            ram_wena      <= 1'b0;
            register_load <= 1'b0;
            branch        <= 1'b0;
            illegal       <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            opcode        <= f_op;
            a_sel         <= f_a;
            dst           <= f_dst;
            b_sel         <= f_b;
            mux_b_addr    <= d_mux;
            ram_read_mux  <= d_rmux;
            store_decoder <= d_st;
            ram_ena       <= d_ena;
            ram_wena      <= d_wena;
            register_load <= d_rl;
            branch        <= d_br;
            illegal       <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RUN: begin
                if (load && d_br && SLOTS != 3'd0) begin
                    state_nx = FLUSH;
                    cnt_nx   = SLOTS;
                end
            end
            FLUSH: begin
                if (accept) begin
                    cnt_nx = cnt - 3'd1;
                    if (cnt == 3'd1) state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a
// transaction-level model of the decode/flush rules.
module tb_decode_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int FS = 2;
    localparam int IW = 7 + 2*RW + DW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [IW-1:0] instruction = '0;
    logic Z = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [4:0] opcode;
    logic [RW-1:0] a_sel, dst;
    logic [DW-1:0] b_sel;
    logic mux_b_addr, ram_read_mux, store_decoder, ram_ena;
    logic ram_wena, register_load, branch, illegal, flush_active;

    int total = 0;
    int bad = 0;

    bit            m_valid;
    logic [4:0]    m_op;
    logic [RW-1:0] m_a, m_d;
    logic [DW-1:0] m_b;
    logic [7:0]    m_ctl;
    int            m_drop;

    always #5 clk = ~clk;

    decode_stage #(
        .DATA_WIDTH (DW),
        .REG_ADDR_W (RW),
        .FLUSH_SLOTS(FS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .Z            (Z),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .opcode       (opcode),
        .a_sel        (a_sel),
        .dst          (dst),
        .b_sel        (b_sel),
        .mux_b_addr   (mux_b_addr),
        .ram_read_mux (ram_read_mux),
        .store_decoder(store_decoder),
        .ram_ena      (ram_ena),
        .ram_wena     (ram_wena),
        .register_load(register_load),
        .branch       (branch),
        .illegal      (illegal),
        .flush_active (flush_active)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [4:0] op,
                                         input logic [1:0] md,
                                         input logic [RW-1:0] a,
                                         input logic [RW-1:0] d,
                                         input logic [DW-1:0] b);
        return {op, md, a, d, b};
    endfunction

    // {mux_b, rd_mux, st_dec, ena, wena, rload, branch, illegal}
    function automatic logic [7:0] ref_ctl(input logic [4:0] op,
                                           input logic [1:0] md,
                                           input logic z);
        logic mx, rm, st, en, we, rl, br, il;
        {mx, rm, st, en, we, rl, br, il} = 8'h00;
        if (md == 2'b11) il = 1'b1;
        else begin
            case (op)
                5'h01: begin rl = 1'b1; en = (md == 2'b01); rm = en; end
                5'h02: begin en = 1'b1; we = 1'b1; st = 1'b1; end
                5'h03, 5'h04, 5'h05, 5'h06,
                5'h07, 5'h08, 5'h09, 5'h0A: rl = 1'b1;
                5'h10: br = z;
                5'h11: br = !z;
                5'h12: br = 1'b1;
                default: il = 1'b1;
            endcase
        end
        mx = !il && (md == 2'b10);
        return {mx, rm, st, en, we, rl, br, il};
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_op = '0;
        m_a = '0;
        m_d = '0;
        m_b = '0;
        m_ctl = '0;
        m_drop = 0;
    endfunction

    task automatic compare();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("flush_active", 64'(flush_active), 64'(m_drop > 0));
        check("opcode", 64'(opcode), 64'(m_op));
        check("a_sel", 64'(a_sel), 64'(m_a));
        check("dst", 64'(dst), 64'(m_d));
        check("b_sel", 64'(b_sel), 64'(m_b));
        check("ctl", 64'({mux_b_addr, ram_read_mux, store_decoder, ram_ena,
                          ram_wena, register_load, branch, illegal}),
              64'(m_ctl));
    endtask

    task automatic step(input logic v, input logic [IW-1:0] ins,
                        input logic z, input logic ordy);
        logic acc, loaded;
        @(negedge clk);
        in_valid = v;
        instruction = ins;
        Z = z;
        out_ready = ordy;
        #1;
        check("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
        acc = v && (!m_valid || ordy);
        loaded = acc && (m_drop == 0);
        if (acc && m_drop > 0) m_drop--;
        if (loaded) begin
            m_op = ins[IW-1 -: 5];
            m_a = ins[IW-8 -: RW];
            m_d = ins[IW-8-RW -: RW];
            m_b = ins[DW-1:0];
            m_ctl = ref_ctl(ins[IW-1 -: 5], ins[IW-6 -: 2], z);
            m_valid = 1'b1;
            if (m_ctl[1]) m_drop = FS;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    logic [4:0] ops [10] = '{5'h01, 5'h02, 5'h03, 5'h07, 5'h0A,
                             5'h10, 5'h11, 5'h12, 5'h1F, 5'h0B};

    initial begin
        model_reset();
        #12;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(0));
        compare();
        @(negedge clk);
        reset = 1'b1;

        step(1, mk(5'h03, 2'b10, 5'd3, 5'd7, 32'd5), 0, 1);
        check("add_rl", 64'(register_load), 64'(1));
        check("add_mux", 64'(mux_b_addr), 64'(1));
        check("add_a", 64'(a_sel), 64'(3));
        check("add_b", 64'(b_sel), 64'(5));

        step(1, mk(5'h01, 2'b01, 5'd1, 5'd2, 32'd9), 0, 1);
        check("ld1_ena", 64'(ram_ena), 64'(1));
        step(1, mk(5'h01, 2'b00, 5'd1, 5'd2, 32'd9), 0, 1);
        check("ld0_ena", 64'(ram_ena), 64'(0));
        check("ld0_rl", 64'(register_load), 64'(1));

        step(1, mk(5'h02, 2'b00, 5'd4, 5'd5, 32'd6), 0, 1);
        step(1, mk(5'h03, 2'b00, 5'd1, 5'd1, 32'd1), 0, 0);
        step(1, mk(5'h03, 2'b00, 5'd1, 5'd1, 32'd1), 0, 0);
        check("st_wena", 64'(ram_wena), 64'(1));
        check("st_hold", 64'(opcode), 64'(2));
        step(1, mk(5'h04, 2'b00, 5'd1, 5'd1, 32'd1), 0, 1);
        check("after_st", 64'(opcode), 64'(4));

        step(1, mk(5'h10, 2'b00, 5'd0, 5'd0, 32'd0), 1, 1);
        check("bz_br", 64'(branch), 64'(1));
        step(1, mk(5'h03, 2'b00, 5'd2, 5'd2, 32'd2), 0, 1);
        step(1, mk(5'h04, 2'b00, 5'd2, 5'd2, 32'd2), 0, 1);
        step(1, mk(5'h05, 2'b00, 5'd6, 5'd6, 32'd6), 0, 1);
        check("xor_op", 64'(opcode), 64'(5));
        check("xor_vld", 64'(out_valid), 64'(1));

        step(1, mk(5'h11, 2'b00, 5'd0, 5'd0, 32'd0), 1, 1);
        check("bnz_br", 64'(branch), 64'(0));
        step(1, mk(5'h1F, 2'b10, 5'd0, 5'd0, 32'd0), 0, 1);
        check("ill_ctl", 64'({mux_b_addr, ram_read_mux, store_decoder,
                              ram_ena, ram_wena, register_load, branch,
                              illegal}), 64'(1));

        step(1, mk(5'h12, 2'b00, 5'd0, 5'd0, 32'd0), 0, 0);
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_flush", 64'(flush_active), 64'(0));
        check("arst_ready", 64'(in_ready), 64'(0));
        model_reset();
        compare();
        @(negedge clk);
        reset = 1'b1;
        step(1, mk(5'h03, 2'b00, 5'd1, 5'd2, 32'd3), 0, 1);
        check("post_rst", 64'(opcode), 64'(3));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0,
                 mk(ops[$urandom_range(9, 0)], 2'($urandom),
                    RW'($urandom), RW'($urandom), DW'($urandom)),
                 1'($urandom), $urandom_range(9, 0) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the B field and b_sel.
REQ-002 Parameter REG_ADDR_W, default 5, width of the A and DST fields.
REQ-003 Parameter FLUSH_SLOTS, default 1, range 0..7, number of instructions discarded after a taken branch.
REQ-004 Derived IW = 7 + 2*REG_ADDR_W + DATA_WIDTH; fields MSB-first: opcode[5], mode[2], A[REG_ADDR_W], DST[REG_ADDR_W], B[DATA_WIDTH].
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 in_valid  input  1  instruction valid; in_ready  output  1  stage can accept.
REQ-008 instruction  input  IW  instruction word; Z  input  1  ALU zero flag.
REQ-009 out_valid  output  1  decoded word valid; out_ready  input  1  downstream accepts.
REQ-010 opcode  output  5; a_sel  output  REG_ADDR_W; dst  output  REG_ADDR_W; b_sel  output  DATA_WIDTH; all registered fields.
REQ-011 mux_b_addr, ram_read_mux, store_decoder, ram_ena, ram_wena, register_load, branch, illegal  output  1 each  registered controls.
REQ-012 flush_active  output  1  high while in FLUSH state.

Function
REQ-013 Accept = in_valid && in_ready; in_ready = reset && (!out_valid || out_ready).
REQ-014 On accept of a non-flushed word, all field and control outputs load and out_valid=1 next cycle.
REQ-015 out_valid clears after out_ready=1 with no new load; outputs hold stable while out_valid && !out_ready.
REQ-016 mux_b_addr = (mode==2'b10).
REQ-017 LD 5'h01: register_load=1; mode 01 -> ram_ena=1, ram_read_mux=1; else both 0.
REQ-018 ST 5'h02: ram_ena=1, ram_wena=1, store_decoder=1, register_load=0.
REQ-019 ALU ops 5'h03..5'h0A: register_load=1, all RAM/store controls 0.
REQ-020 BZ 5'h10: branch=Z; BNZ 5'h11: branch=!Z; BRA 5'h12: branch=1; register_load=0, RAM controls 0.
REQ-021 Z sampled in the accept cycle.
REQ-022 Any other opcode, or mode==2'b11: illegal=1, all other controls 0 (NOP); word still passes with out_valid.
REQ-023 Every control not named for an opcode is 0; no latched/held controls.
REQ-024 FSM states RUN, FLUSH; 3-bit counter cnt.
REQ-025 RUN: accepted word with branch=1 and FLUSH_SLOTS>0 -> FLUSH, cnt=FLUSH_SLOTS; FLUSH_SLOTS=0 stays RUN.
REQ-026 FLUSH: each accepted word is dropped (no load, out_valid unaffected, cannot branch); cnt decrements; accept with cnt==1 -> RUN.
REQ-027 FLUSH with no accept holds state and cnt.
REQ-028 flush_active = (state==FLUSH).

Reset
REQ-029 reset=0 immediately forces: out_valid=0, in_ready=0, all fields and controls 0, state RUN, cnt 0.
REQ-030 Reset mid-FLUSH or mid-stall discards pending word and flush count; first accept after release is decoded in RUN.

Verification
REQ-031 ADD 5'h03, mode 10, A=3, DST=7, B=5, out_ready=1 -> next cycle out_valid=1, register_load=1, mux_b_addr=1, a_sel=3, dst=7, b_sel=5.
REQ-032 LD mode 01 then LD mode 00 -> ram_ena/ram_read_mux 1 then 0; register_load=1 both.
REQ-033 out_ready=0 two cycles after ST -> in_ready=0, outputs held, ram_wena=1; out_ready=1 -> next word accepted.
REQ-034 FLUSH_SLOTS=2: BZ with Z=1, then ADD, SUB, XOR -> branch=1 pulse word, ADD/SUB dropped, flush_active 2 accepts, XOR emitted.
REQ-035 BNZ with Z=1 -> branch=0, no FLUSH; opcode 5'h1F -> illegal=1, all enables 0.
REQ-036 reset=0 asserted during FLUSH with out_valid=1 -> out_valid=0, flush_active=0 immediately, no clock required.
